branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Next-generation branch block. Holds the architectural flag register [N,V,Z].
- Resolves the 3-bit branch condition against those flags, using a 1-cycle registered result.
- Adds a parametrised bimodal branch history table (BHT) of saturating counters for fetch-stage prediction, and flags mispredictions.
- Sits between fetch (prediction lookup) and execute (flag write and branch resolution).

Parameters:
- PC_W, 16, width of the program counter used for indexing.
- BHT_DEPTH, 16, number of BHT entries; must be a power of 2 and at least 2.
- CTR_W, 2, width of each saturating counter; must be at least 2.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- flag_we  in  1  write flag_in into the flag register this cycle.
- flag_in  in  3  new flags [2]=N [1]=V [0]=Z.
- flag_q  out  3  current flag register.
- pred_pc  in  PC_W  fetch PC to look up.
- pred_taken  out  1  combinational prediction for pred_pc.
- res_valid  in  1  a branch is resolving this cycle.
- res_pc  in  PC_W  PC of the resolving branch.
- res_cond  in  3  condition code ccc.
- res_pred_taken  in  1  prediction that was made for this branch at fetch.
- out_valid  out  1  registered; resolution result is valid.
- out_taken  out  1  registered; actual branch outcome.
- mispredict  out  1  registered; out_taken differs from res_pred_taken.

Behaviour:
- Reset (async, rst_n=0):
  - flag_q=3'b000; out_valid=out_taken=mispredict=0.
  - Every BHT counter is set to weakly-not-taken, 2^(CTR_W-1)-1 (2'b01 for CTR_W=2).
- Flag register:
  - flag_q <= flag_in on a clk rising edge when flag_we=1; otherwise it holds.
- Condition table (cond_eval):
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GTE: Z | ~N
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- Flag forwarding:
  - If flag_we and res_valid are both 1 in the same cycle, the condition is evaluated on flag_in, not flag_q.
  - Otherwise it is evaluated on flag_q.
- Resolution latency is 1 cycle. On the edge where res_valid=1:
  - out_valid <= 1.
  - out_taken <= evaluated condition.
  - mispredict <= evaluated condition XOR res_pred_taken.
  - When res_valid=0, out_valid, out_taken and mispredict all register to 0.
- Indexing:
  - idx = pc[log2(BHT_DEPTH):1]. Bit 0 is ignored because instructions are 16-bit aligned.
  - The same mapping is used for pred_pc and res_pc.
- Prediction:
  - pred_taken = MSB of counter[idx(pred_pc)].
  - Purely combinational; no valid qualifier.
- BHT update, on res_valid=1 only:
  - Taken: counter increments, saturating at all-ones.
  - Not taken: counter decrements, saturating at 0.
  - UNCOND (111) never updates the BHT.
- Read/write collision:
  - When the lookup and update hit the same index in the same cycle, pred_taken reflects the pre-update value (read-before-write).
- Reset mid-operation:
  - Asserting rst_n low clears a pending result immediately, without waiting for clk.
  - No out_valid pulse is emitted after reset is released.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds outputs stat_branches (16 bits) and stat_mispredicts (16 bits).
  - stat_branches increments on each out_valid=1 cycle.
  - stat_mispredicts increments on each mispredict=1 cycle.
  - Both saturate at 16'hFFFF and reset to 0.
- When not defined: these ports and registers do not exist, and all other behaviour is identical.

Decomposition:
- Package branch_pkg holds:
  - cond_t enum (NE, EQ, GT, LT, GTE, LTE, OVFL, UNCOND).
  - Flag bit index constants FLAG_N=2, FLAG_V=1, FLAG_Z=0.
  - Function cond_eval(cond_t, logic [2:0] flags) returning logic.
- Sub-module branch_bht(BHT_DEPTH, CTR_W) holds:
  - The counter array, the reset initialisation, the combinational read port and the saturating update port.

Test Plan:
- Reset, then pred_pc=16'h0004 -> pred_taken=0 and flag_q=000; with res_valid=0, out_valid stays 0.
- flag_we=1, flag_in=001 (Z); next cycle res_valid=1, res_cond=001, res_pred_taken=0 -> next edge: out_valid=1, out_taken=1, mispredict=1.
- Same cycle: flag_we=1, flag_in=100 (N) with res_valid=1, res_cond=011 (LT), flag_q=000 -> out_taken=1, proving forwarding of flag_in.
- Three taken resolutions at res_pc=16'h0010, then pred_pc=16'h0010 -> pred_taken=1 and counter=11; two not-taken resolutions -> counter=01, pred_taken=0.
- Collision: res_pc=pred_pc=16'h0020 with counter=01, resolved taken -> pred_taken=0 that cycle and 1 the next; res_cond=111 leaves the counter unchanged.
- rst_n pulled low mid-cycle after res_valid -> out_valid=0 immediately; with BRANCH_STATS_EN defined, 5 resolutions including 2 mispredicts -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predict unit: condition codes,
// flag bit positions and the condition evaluator used at resolution time.
package branch_pkg;

    typedef enum logic [2:0] {
        NE     = 3'b000,
        EQ     = 3'b001,
        GT     = 3'b010,
        LT     = 3'b011,
        GTE    = 3'b100,
        LTE    = 3'b101,
        OVFL   = 3'b110,
        UNCOND = 3'b111
    } cond_t;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Resolve a condition code against an [N,V,Z] flag vector.
    function automatic logic cond_eval(input cond_t cond, input logic [2:0] flags);
        logic n;
        logic v;
        logic z;
        logic result;
        n = flags[FLAG_N];
        v = flags[FLAG_V];
        z = flags[FLAG_Z];
        case (cond)
            NE:      result = ~z;
            EQ:      result = z;
            GT:      result = ~z & ~n;
            LT:      result = n;
            GTE:     result = z | ~n;
            LTE:     result = n | z;
            OVFL:    result = v;
            UNCOND:  result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Bimodal branch history table: an array of saturating counters with one
// combinational read port (prediction) and one synchronous update port
// (resolution). Reads see the pre-update value on a same-index collision.
module branch_bht #(
    parameter int BHT_DEPTH = 16,
    parameter int CTR_W     = 2,
    localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN  = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};

    logic [CTR_W-1:0] ctr_r [BHT_DEPTH];
    logic [CTR_W-1:0] wr_cur_s;
    logic [CTR_W-1:0] wr_next_s;

    // Prediction is the counter MSB; the array is read directly so a
    // concurrent update only becomes visible after the clock edge.
    assign rd_taken = ctr_r[rd_idx][CTR_W-1];

    // Saturating increment/decrement of the addressed counter.
    always_comb begin
        wr_cur_s  = ctr_r[wr_idx];
        wr_next_s = wr_cur_s;
        if (wr_taken) begin
            if (wr_cur_s != CTR_MAX) begin
                wr_next_s = wr_cur_s + CTR_ONE;
            end else begin
                wr_next_s = wr_cur_s;
            end
        end else begin
            if (wr_cur_s != CTR_MIN) begin
                wr_next_s = wr_cur_s - CTR_ONE;
            end else begin
                wr_next_s = wr_cur_s;
            end
        end
    end

    // Counter array: all entries start weakly-not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_r[i] <= CTR_INIT;
            end
        end else if (wr_en) begin
            ctr_r[wr_idx] <= wr_next_s;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: architectural [N,V,Z] flag register, one-cycle
// registered branch resolution with flag forwarding, and a bimodal BHT for
// fetch-stage prediction with misprediction flagging.
// Optional feature macro: BRANCH_STATS_EN adds saturating branch and
// mispredict counters (stat_branches, stat_mispredicts).
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16,
    parameter int CTR_W     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_we,
    input  logic [2:0]      flag_in,
    output logic [2:0]      flag_q,
    input  logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [PC_W-1:0] res_pc,
    input  logic [2:0]      res_cond,
    input  logic            res_pred_taken,
    output logic            out_valid,
    output logic            out_taken,
    output logic            mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] pred_idx_s;
    logic [IDX_W-1:0] res_idx_s;
    logic [2:0]       eval_flags_s;
    cond_t            cond_s;
    logic             taken_s;
    logic             bht_upd_s;
    logic             unused_pc_bits;

    // Halfword-aligned instructions: bit 0 never distinguishes branches.
    assign pred_idx_s = pred_pc[IDX_W:1];
    assign res_idx_s  = res_pc[IDX_W:1];
    assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+1], pred_pc[0],
                              res_pc[PC_W-1:IDX_W+1], res_pc[0]};

    assign cond_s = cond_t'(res_cond);

    // Pick forwarded flags when execute writes and resolves in one cycle.
    always_comb begin
        eval_flags_s = flag_q;
        if (flag_we && res_valid) begin
            eval_flags_s = flag_in;
        end else begin
            eval_flags_s = flag_q;
        end
    end

    assign taken_s   = cond_eval(cond_s, eval_flags_s);
    // Unconditional branches carry no direction information for the BHT.
    assign bht_upd_s = res_valid && (cond_s != UNCOND);

    branch_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .CTR_W     (CTR_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pred_idx_s),
        .rd_taken (pred_taken),
        .wr_en    (bht_upd_s),
        .wr_idx   (res_idx_s),
        .wr_taken (taken_s)
    );

    // Architectural flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 3'b000;
        end else if (flag_we) begin
            flag_q <= flag_in;
        end
    end

    // Registered resolution result; idle cycles clear all three outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else if (res_valid) begin
            out_valid  <= 1'b1;
            out_taken  <= taken_s;
            mispredict <= taken_s ^ res_pred_taken;
        end else begin
            out_valid  <= 1'b0;
            out_taken  <= 1'b0;
            mispredict <= 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating event counters driven by the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= 16'h0000;
            stat_mispredicts <= 16'h0000;
        end else begin
            if (out_valid && (stat_branches != 16'hFFFF)) begin
                stat_branches <= stat_branches + 16'h0001;
            end
            if (mispredict && (stat_mispredicts != 16'hFFFF)) begin
                stat_mispredicts <= stat_mispredicts + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit. Honours BRANCH_STATS_EN.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic        flag_we;
    logic [2:0]  flag_in;
    logic [2:0]  flag_q;
    logic [15:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [15:0] res_pc;
    logic [2:0]  res_cond;
    logic        res_pred_taken;
    logic        out_valid;
    logic        out_taken;
    logic        mispredict;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    int compared;
    int mismatched;

    branch_predict_unit #(
        .PC_W      (16),
        .BHT_DEPTH (16),
        .CTR_W     (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flag_we        (flag_we),
        .flag_in        (flag_in),
        .flag_q         (flag_q),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_cond       (res_cond),
        .res_pred_taken (res_pred_taken),
        .out_valid      (out_valid),
        .out_taken      (out_taken),
        .mispredict     (mispredict)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags_set(input logic [2:0] f);
        flag_we   = 1'b1;
        flag_in   = f;
        res_valid = 1'b0;
        tick();
        flag_we   = 1'b0;
    endtask

    task automatic resolve(input logic [15:0] pc, input logic [2:0] cond, input logic pt);
        res_valid      = 1'b1;
        res_pc         = pc;
        res_cond       = cond;
        res_pred_taken = pt;
        tick();
        res_valid      = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] exp_tab;
        logic [2:0] flag_set_tab [3];
        logic [7:0] exp_set_tab [3];

        compared   = 0;
        mismatched = 0;
        rst_n          = 1'b0;
        flag_we        = 1'b0;
        flag_in        = 3'b000;
        pred_pc        = 16'h0004;
        res_valid      = 1'b0;
        res_pc         = 16'h0000;
        res_cond       = 3'b000;
        res_pred_taken = 1'b0;

        // Reset state
        #2;
        check("rst_flag_q", {13'd0, flag_q}, 16'h0000);
        check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        check("rst_pred_0004", {15'd0, pred_taken}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_out_valid", {15'd0, out_valid}, 16'h0000);

        // Flag write then resolve EQ with wrong prediction
        flags_set(3'b001);
        check("flag_q_z", {13'd0, flag_q}, 16'h0001);
        check("flagwr_out_valid", {15'd0, out_valid}, 16'h0000);
        resolve(16'h001E, 3'b001, 1'b0);
        check("eq_out_valid", {15'd0, out_valid}, 16'h0001);
        check("eq_out_taken", {15'd0, out_taken}, 16'h0001);
        check("eq_mispredict", {15'd0, mispredict}, 16'h0001);

        // Forwarding: flag_q=000, flag_in=100 written with LT resolving
        flags_set(3'b000);
        flag_we = 1'b1;
        flag_in = 3'b100;
        resolve(16'h001E, 3'b011, 1'b1);
        flag_we = 1'b0;
        check("fwd_lt_taken", {15'd0, out_taken}, 16'h0001);
        check("fwd_lt_mispredict", {15'd0, mispredict}, 16'h0000);
        check("fwd_flag_q", {13'd0, flag_q}, 16'h0004);
        // Forwarding the other way: flag_q=100 but flag_in=000 evaluated
        flag_we = 1'b1;
        flag_in = 3'b000;
        resolve(16'h001E, 3'b011, 1'b1);
        flag_we = 1'b0;
        check("fwd2_lt_taken", {15'd0, out_taken}, 16'h0000);
        check("fwd2_mispredict", {15'd0, mispredict}, 16'h0001);

        // Condition table sweep over three flag patterns
        flag_set_tab[0] = 3'b100; exp_set_tab[0] = 8'b1010_1001;
        flag_set_tab[1] = 3'b010; exp_set_tab[1] = 8'b1101_0101;
        flag_set_tab[2] = 3'b001; exp_set_tab[2] = 8'b1011_0010;
        for (int s = 0; s < 3; s++) begin
            flags_set(flag_set_tab[s]);
            exp_tab = exp_set_tab[s];
            for (int c = 0; c < 8; c++) begin
                resolve(16'h001E, 3'(c), 1'(c));
                check($sformatf("cond%0d_f%0h_taken", c, flag_set_tab[s]),
                      {15'd0, out_taken}, {15'd0, exp_tab[c]});
                check($sformatf("cond%0d_f%0h_misp", c, flag_set_tab[s]),
                      {15'd0, mispredict}, {15'd0, exp_tab[c] ^ 1'(c)});
            end
        end

        // BHT saturation at index 8 (pc 0x0010); flags are Z
        pred_pc = 16'h0010;
        resolve(16'h0010, 3'b001, 1'b0);
        resolve(16'h0010, 3'b001, 1'b1);
        resolve(16'h0010, 3'b001, 1'b1);
        check("bht_3taken_pred", {15'd0, pred_taken}, 16'h0001);
        pred_pc = 16'h0011;
        #1;
        check("bht_bit0_alias", {15'd0, pred_taken}, 16'h0001);
        pred_pc = 16'h0010;
        resolve(16'h0010, 3'b000, 1'b1);
        check("bht_nt1_mispredict", {15'd0, mispredict}, 16'h0001);
        check("bht_nt1_pred", {15'd0, pred_taken}, 16'h0001);
        resolve(16'h0010, 3'b000, 1'b1);
        check("bht_nt2_pred", {15'd0, pred_taken}, 16'h0000);
        resolve(16'h0010, 3'b000, 1'b0);
        resolve(16'h0010, 3'b000, 1'b0);
        resolve(16'h0010, 3'b001, 1'b0);
        check("bht_min_sat_t1", {15'd0, pred_taken}, 16'h0000);
        resolve(16'h0010, 3'b001, 1'b0);
        check("bht_min_sat_t2", {15'd0, pred_taken}, 16'h0001);

        // Read/write collision at pc 0x0020 (counter 01)
        pred_pc        = 16'h0020;
        res_valid      = 1'b1;
        res_pc         = 16'h0020;
        res_cond       = 3'b001;
        res_pred_taken = 1'b0;
        #1;
        check("collide_pre_update", {15'd0, pred_taken}, 16'h0000);
        tick();
        res_valid = 1'b0;
        #1;
        check("collide_post_update", {15'd0, pred_taken}, 16'h0001);
        resolve(16'h0020, 3'b111, 1'b1);
        check("uncond_taken", {15'd0, out_taken}, 16'h0001);
        check("uncond_mispredict", {15'd0, mispredict}, 16'h0000);
        check("uncond_pred_hold", {15'd0, pred_taken}, 16'h0001);
        resolve(16'h0020, 3'b000, 1'b0);
        check("uncond_no_update", {15'd0, pred_taken}, 16'h0000);

        // Asynchronous reset mid-cycle with a pending result
        pred_pc = 16'h0010;
        #1;
        check("pre_rst_pred", {15'd0, pred_taken}, 16'h0001);
        res_valid      = 1'b1;
        res_pc         = 16'h001E;
        res_cond       = 3'b111;
        res_pred_taken = 1'b1;
        tick();
        check("pre_rst_out_valid", {15'd0, out_valid}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {15'd0, out_valid}, 16'h0000);
        check("async_rst_out_taken", {15'd0, out_taken}, 16'h0000);
        check("async_rst_flag_q", {13'd0, flag_q}, 16'h0000);
        check("async_rst_bht", {15'd0, pred_taken}, 16'h0000);
        res_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_no_pulse", {15'd0, out_valid}, 16'h0000);

`ifdef BRANCH_STATS_EN
        // Statistics: 5 resolutions, 2 mispredicts
        check("stat_br_reset", stat_branches, 16'h0000);
        flags_set(3'b001);
        resolve(16'h0030, 3'b001, 1'b1);
        resolve(16'h0030, 3'b001, 1'b0);
        resolve(16'h0030, 3'b111, 1'b1);
        resolve(16'h0030, 3'b000, 1'b1);
        resolve(16'h0030, 3'b000, 1'b0);
        tick();
        tick();
        check("stat_branches", stat_branches, 16'h0005);
        check("stat_mispredicts", stat_mispredicts, 16'h0002);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
